// File: rtl/prog_counter_pkg.sv
// Shared mode/state types for prog_counter and its ONESHOT sequencer.
// Encodings match the 2-bit mode port; the reserved code decodes to WRAP.
package prog_counter_pkg;

  localparam logic [1:0] MODE_ENC_WRAP     = 2'b00;
  localparam logic [1:0] MODE_ENC_SATURATE = 2'b01;
  localparam logic [1:0] MODE_ENC_ONESHOT  = 2'b10;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SATURATE = 2'b01,
    MODE_ONESHOT  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } os_state_e;

  function automatic mode_e decode_mode(input logic [1:0] enc);
    case (enc)
      MODE_ENC_WRAP:     return MODE_WRAP;
      MODE_ENC_SATURATE: return MODE_SATURATE;
      MODE_ENC_ONESHOT:  return MODE_ONESHOT;
      default:           return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/prog_counter_oneshot_fsm.sv
// ONESHOT run sequencer (IDLE -> RUN -> DONE -> IDLE); state registered, arm/finish are same-cycle strobes.
// No backpressure: clear, load and leaving ONESHOT mode always win over the run.
module prog_counter_oneshot_fsm
  import prog_counter_pkg::*;
(
  input  logic clk_25m,
  input  logic reset,
  input  logic oneshot_en,
  input  logic clear,
  input  logic load,
  input  logic start,
  input  logic enable,
  input  logic at_term,
  output logic busy,
  output logic arm,
  output logic finish
);

  os_state_e state;
  os_state_e state_nxt;

  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clear and load outrank the run, so a load never starts or finishes one
  always_comb begin
    state_nxt = state;
    if (!oneshot_en || clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start && !load) state_nxt = ST_RUN;
        ST_RUN:  if (!load && enable && at_term) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state == ST_RUN);
    arm    = 1'b0;
    finish = 1'b0;
    if (oneshot_en && !clear && !load) begin
      arm    = (state == ST_IDLE) && start;
      finish = (state == ST_RUN) && enable && at_term;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with WRAP/SATURATE/ONESHOT modes; 1-cycle registered count, no backpressure.
// Optional match compare port pair is built only with PROG_COUNTER_MATCH_EN defined.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int RESET_MAX = 799
) (
  input  logic             clk_25m,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             start,
`ifdef PROG_COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] match_value,
  output logic             match_pulse,
`endif
  output logic [WIDTH-1:0] count,
  output logic             counter_tick,
  output logic             wrap_pulse,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] start_pos;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] count_nxt;
  logic             at_term;
  logic             wrap_evt;
  logic             oneshot_en;
  logic             os_arm;
  logic             os_finish;
  mode_e            mode_d;

  assign mode_d     = decode_mode(mode);
  assign oneshot_en = (mode_d == MODE_ONESHOT);

  // Up terminal uses >= so a lowered max_value is caught immediately
  always_comb begin
    at_term      = dir ? (count == '0) : (count >= max_q);
    start_pos    = dir ? max_q : '0;
    load_clamped = (load_value > max_q) ? max_q : load_value;
    if (dir) begin
      step_val = (count > max_q) ? max_q : (count - ONE);
    end else begin
      step_val = count + ONE;
    end
  end

  assign counter_tick = at_term;

  prog_counter_oneshot_fsm u_oneshot_fsm (
    .clk_25m    (clk_25m),
    .reset      (reset),
    .oneshot_en (oneshot_en),
    .clear      (clear),
    .load       (load),
    .start      (start),
    .enable     (enable),
    .at_term    (at_term),
    .busy       (busy),
    .arm        (os_arm),
    .finish     (os_finish)
  );

  always_comb begin
    count_nxt = count;
    wrap_evt  = 1'b0;
    if (clear) begin
      count_nxt = start_pos;
    end else if (load) begin
      count_nxt = load_clamped;
    end else if (oneshot_en) begin
      // a finishing step holds at terminal
      if (os_arm) begin
        count_nxt = start_pos;
      end else if (busy && enable && !at_term) begin
        count_nxt = step_val;
      end
    end else if (enable) begin
      if (!at_term) begin
        count_nxt = step_val;
      end else if (mode_d == MODE_WRAP) begin
        count_nxt = start_pos;
        wrap_evt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      max_q      <= WIDTH'(RESET_MAX);
    end else begin
      count      <= count_nxt;
      wrap_pulse <= wrap_evt | os_finish;
      max_q      <= max_value;
    end
  end

`ifdef PROG_COUNTER_MATCH_EN
  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= enable && (count == match_value);
    end
  end
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: vector table plus hand sequences, expectations queued per drive.
// Defining PROG_COUNTER_MATCH_EN also exercises the match port pair.
module tb_prog_counter;

  logic       clk_25m = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [9:0] load_value = '0;
  logic [9:0] max_value = 10'd799;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       start = 1'b0;
  logic [9:0] count;
  logic       counter_tick;
  logic       wrap_pulse;
  logic       busy;
`ifdef PROG_COUNTER_MATCH_EN
  logic [9:0] match_value = 10'd1023;
  logic       match_pulse;
`endif

  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  typedef struct {
    logic       clr, ld, en, st, dr;
    logic [1:0] md;
    logic [9:0] lv, mv;
    int         e_cnt;
    logic       e_tick, e_wrap, e_busy, e_match;
    int         id;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #20 clk_25m = ~clk_25m;

  prog_counter #(.WIDTH(10), .RESET_MAX(799)) dut (
    .clk_25m      (clk_25m),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .load         (load),
    .load_value   (load_value),
    .max_value    (max_value),
    .dir          (dir),
    .mode         (mode),
    .start        (start),
`ifdef PROG_COUNTER_MATCH_EN
    .match_value  (match_value),
    .match_pulse  (match_pulse),
`endif
    .count        (count),
    .counter_tick (counter_tick),
    .wrap_pulse   (wrap_pulse),
    .busy         (busy)
  );

  function automatic vec_t mk(input int clr, input int ld, input int en, input int st,
                              input int dr, input int md, input int lv, input int mv,
                              input int cnt, input int tk, input int wr, input int bz);
    vec_t v;
    v.clr = (clr != 0); v.ld = (ld != 0); v.en = (en != 0); v.st = (st != 0);
    v.dr = (dr != 0); v.md = md[1:0]; v.lv = lv[9:0]; v.mv = mv[9:0];
    v.e_cnt = cnt; v.e_tick = (tk != 0); v.e_wrap = (wr != 0); v.e_busy = (bz != 0);
    v.e_match = 1'b0; v.id = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0d expected %0d", nm, id, got, exp);
    end
  endtask

  // drive on the falling edge, queue the expectation, compare 1 ns after the rising edge
  task automatic drive(input vec_t v);
    vec_t e;
    @(negedge clk_25m);
    clear = v.clr; load = v.ld; enable = v.en; start = v.st;
    dir = v.dr; mode = v.md; load_value = v.lv; max_value = v.mv;
    v.id = vec_id++;
    sb.push_back(v);
    @(posedge clk_25m);
    #1;
    e = sb.pop_front();
    chk("count", e.id, int'(count), e.e_cnt);
    chk("counter_tick", e.id, int'(counter_tick), int'(e.e_tick));
    chk("wrap_pulse", e.id, int'(wrap_pulse), int'(e.e_wrap));
    chk("busy", e.id, int'(busy), int'(e.e_busy));
`ifdef PROG_COUNTER_MATCH_EN
    chk("match_pulse", e.id, int'(match_pulse), int'(e.e_match));
`endif
  endtask

  initial begin
    #(50000 * 40);
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int exp_c;
    vec_t v;

    // WRAP down, max 5, from 0
    tbl.push_back(mk(0,0,0,0,1,0,  0,5,   0,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   5,0,1,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   4,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   3,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   2,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   1,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   0,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,5,   5,0,1,0));
    // SATURATE up, max 3
    tbl.push_back(mk(1,0,1,0,0,1,  0,3,   0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,3,   1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,3,   2,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,3,   3,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,3,   3,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,3,   3,1,0,0));
    // priority and load clamp
    tbl.push_back(mk(1,1,1,0,0,0,  900,799, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,  900,799, 799,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,  0,799,   0,0,1,0));
    // max lowered below count
    tbl.push_back(mk(0,1,0,0,0,0,  50,799, 50,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,20,   50,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,  0,20,   0,0,1,0));
    // down count above max reloads max
    tbl.push_back(mk(0,1,0,0,0,0,  15,20,  15,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,  0,10,   15,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,10,   10,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,10,   9,0,0,0));
    // max_value = 0
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,    9,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,  0,0,    0,1,1,0));
    tbl.push_back(mk(0,0,1,0,0,0,  0,0,    0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,  0,0,    0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,0,    0,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,  0,0,    0,1,1,0));
    // reserved mode behaves as WRAP
    tbl.push_back(mk(0,0,0,0,0,3,  0,2,    0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,3,  0,2,    1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,3,  0,2,    2,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,3,  0,2,    0,0,1,0));

    repeat (2) @(posedge clk_25m);
    #1;
    chk("reset_count", -1, int'(count), 0);
    chk("reset_wrap", -1, int'(wrap_pulse), 0);
    chk("reset_busy", -1, int'(busy), 0);
    chk("reset_tick", -1, int'(counter_tick), 0);
    @(negedge clk_25m);
    reset = 1'b0;

    foreach (tbl[i]) drive(tbl[i]);

    // ONESHOT up, max 4: busy for counts 0..4, one wrap_pulse, mid-run start ignored
    drive(mk(1,0,1,0,0,2, 0,4, 0,0,0,0));
    drive(mk(0,0,1,0,0,2, 0,4, 0,0,0,0));
    drive(mk(0,0,1,1,0,2, 0,4, 0,0,0,1));
    drive(mk(0,0,1,0,0,2, 0,4, 1,0,0,1));
    drive(mk(0,0,1,1,0,2, 0,4, 2,0,0,1));
    drive(mk(0,0,1,0,0,2, 0,4, 3,0,0,1));
    drive(mk(0,0,1,0,0,2, 0,4, 4,1,0,1));
    drive(mk(0,0,1,0,0,2, 0,4, 4,1,1,0));
    drive(mk(0,0,1,0,0,2, 0,4, 4,1,0,0));
    drive(mk(0,0,1,0,0,2, 0,4, 4,1,0,0));
    // ONESHOT down, then clear aborts, then mode change aborts
    drive(mk(0,0,0,1,1,2, 0,4, 4,0,0,1));
    drive(mk(0,0,0,0,1,2, 0,4, 4,0,0,1));
    drive(mk(0,0,1,0,1,2, 0,4, 3,0,0,1));
    drive(mk(1,0,1,0,1,2, 0,4, 4,0,0,0));
    drive(mk(0,0,0,1,0,2, 0,4, 0,0,0,1));
    drive(mk(0,0,1,0,0,0, 0,4, 1,0,0,0));
    // reset during RUN
    drive(mk(1,0,0,0,0,2, 0,4, 0,0,0,0));
    drive(mk(0,0,1,1,0,2, 0,4, 0,0,0,1));
    drive(mk(0,0,1,0,0,2, 0,4, 1,0,0,1));
    drive(mk(0,0,1,0,0,2, 0,4, 2,0,0,1));
    @(negedge clk_25m);
    reset = 1'b1;
    #5;
    chk("async_rst_count", -2, int'(count), 0);
    chk("async_rst_busy", -2, int'(busy), 0);
    chk("async_rst_wrap", -2, int'(wrap_pulse), 0);
    @(negedge clk_25m);
    reset = 1'b0;
    drive(mk(0,0,1,0,0,2, 0,4, 0,0,0,0));
    drive(mk(0,0,1,0,0,2, 0,4, 0,0,0,0));

    // WRAP up, max 799, two full 800-cycle periods
    drive(mk(1,0,0,0,0,0, 0,799, 0,0,0,0));
    prev = 0;
    for (int i = 0; i < 1601; i++) begin
      exp_c = (prev == 799) ? 0 : prev + 1;
      drive(mk(0,0,1,0,0,0, 0,799, exp_c, int'(exp_c == 799), int'(prev == 799), 0));
      prev = exp_c;
    end

`ifdef PROG_COUNTER_MATCH_EN
    match_value = 10'd10;
    drive(mk(1,0,0,0,0,0, 0,20, 0,0,0,0));
    prev = 0;
    for (int i = 0; i < 43; i++) begin
      exp_c = (prev == 20) ? 0 : prev + 1;
      v = mk(0,0,1,0,0,0, 0,20, exp_c, int'(exp_c == 20), int'(prev == 20), 0);
      v.e_match = (prev == 10);
      drive(v);
      prev = exp_c;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the counter width in bits (legal 2..32).
REQ-002 Parameter RESET_MAX, default 799, SHALL set the power-up terminal value used until the first max_value sample.
REQ-003 Port clk_25m  in  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port enable  in  1  SHALL advance the count one step per cycle when high.
REQ-006 Port clear  in  1  SHALL force a synchronous return to the start position.
REQ-007 Port load  in  1  SHALL synchronously load load_value.
REQ-008 Port load_value  in  WIDTH  SHALL be the value to load.
REQ-009 Port max_value  in  WIDTH  SHALL be the runtime terminal value, sampled every cycle.
REQ-010 Port dir  in  1  SHALL select direction: 0 = up, 1 = down.
REQ-011 Port mode  in  2  SHALL select behaviour: 00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved (treated as WRAP).
REQ-012 Port start  in  1  SHALL arm a ONESHOT run.
REQ-013 Port count  out  WIDTH  SHALL be the registered count.
REQ-014 Port counter_tick  out  1  SHALL be high combinationally while count is at the terminal position.
REQ-015 Port wrap_pulse  out  1  SHALL be a registered one-cycle pulse following each wrap (WRAP mode) or run completion (ONESHOT mode).
REQ-016 Port busy  out  1  SHALL be high while ONESHOT is in RUN.

Function
REQ-017 Start position SHALL be 0 (up) or max_value (down); terminal position SHALL be max_value (up) or 0 (down).
REQ-018 Up-mode terminal detection SHALL use count >= max_value, so a max_value lowered below count is treated as terminal on the next enabled cycle.
REQ-019 Priority SHALL be clear > load > enable; mode and dir changes SHALL take effect on the next edge.
REQ-020 load_value greater than max_value SHALL load max_value (clamp).
REQ-021 WRAP: enabled step at terminal SHALL move to the start position and assert wrap_pulse on the following cycle.
REQ-022 SATURATE: enabled step at terminal SHALL hold count; wrap_pulse SHALL stay low.
REQ-023 ONESHOT: an FSM with states IDLE, RUN, DONE SHALL be implemented.
REQ-024 In IDLE, count SHALL hold; start SHALL load the start position and move the FSM to RUN.
REQ-025 In RUN, count SHALL step while enabled; an enabled step at terminal SHALL move the FSM to DONE with count held at terminal.
REQ-026 DONE SHALL assert wrap_pulse for one cycle and return to IDLE on the next cycle.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 clear in ONESHOT SHALL return the FSM to IDLE.
REQ-029 Leaving ONESHOT mode SHALL force the FSM to IDLE.
REQ-030 max_value = 0 SHALL hold count at 0 with counter_tick constantly high; in WRAP it SHALL pulse wrap_pulse on every enabled cycle.
REQ-031 Down-mode count above max_value SHALL reload max_value on the next enabled step.
REQ-032 Arithmetic SHALL be WIDTH-bit unsigned with no carry out of WIDTH.

Reset
REQ-033 reset SHALL asynchronously set count = 0, wrap_pulse = 0, busy = 0, the FSM to IDLE, and the internal terminal register to RESET_MAX.
REQ-034 reset asserted mid-run SHALL abort the run without emitting wrap_pulse.

Configuration
REQ-035 With PROG_COUNTER_MATCH_EN defined, ports match_value (in, WIDTH) and match_pulse (out, 1) SHALL exist.
REQ-036 match_pulse SHALL be registered and go high for one cycle after an enabled cycle with count == match_value; it SHALL reset to 0.
REQ-037 Without PROG_COUNTER_MATCH_EN, both ports and the match logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-038 A shared package prog_counter_pkg SHALL hold the mode typedef (WRAP, SATURATE, ONESHOT), the FSM state typedef, and the mode encodings.
REQ-039 The ONESHOT FSM SHALL be a sub-module prog_counter_oneshot_fsm; the datapath SHALL remain in prog_counter.

Verification
REQ-040 WIDTH=10, max=799, WRAP, up, enable=1: count 0..799 then 0; wrap_pulse high one cycle after 799->0; period 800 cycles.
REQ-041 WRAP, down, max=5, from 0: sequence 0,5,4,3,2,1,0; counter_tick high at 0 only.
REQ-042 SATURATE, up, max=3: count 0,1,2,3,3,3; wrap_pulse never asserted.
REQ-043 ONESHOT, max=4, start pulse: busy high 5 cycles covering counts 0..4; wrap_pulse one cycle; IDLE; a second start mid-run is ignored.
REQ-044 Simultaneous clear+load+enable with load_value=900, max=799: count=0; then load alone gives count=799; reset asserted during RUN gives count=0, busy=0, no wrap_pulse.
REQ-045 With PROG_COUNTER_MATCH_EN defined, match_value=10, WRAP, max=20: match_pulse once per 21-cycle period, one cycle after count=10.
